// File: rtl/mux_nx1_scan.sv
// Registered N-to-1 multiplexer with direct-select and round-robin scan modes, valid/ready output.
// Optional even-parity output out_par when MUX_PARITY_EN is defined.
module mux_nx1_scan #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    ch_en,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            load,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_ch,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef MUX_PARITY_EN
  output logic            out_par,
`endif
  output logic            sel_err
);

  localparam logic [SELW-1:0] LAST  = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT = (SELW + 1)'(N);

  logic [W-1:0]    ch_data [N];
  logic            mode_q;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] base;
  logic [SELW-1:0] ptr_nxt;
  logic            slot_free;
  logic            sel_ok;
  logic            scan_hit;
  logic [SELW-1:0] scan_tgt;
  logic            cap;
  logic [SELW-1:0] cap_ch;
  logic [W-1:0]    cap_data;

  for (genvar k = 0; k < N; k++) begin : g_split
    assign ch_data[k] = in_data[k*W +: W];
  end

  assign slot_free = !out_valid || out_ready;
  assign sel_ok    = ({1'b0, sel} < N_EXT);
  // A mode change restarts the scan so the lowest enabled channel comes first
  assign base      = (mode != mode_q) ? LAST : ptr;

  always_comb begin
    int idx;
    scan_hit = 1'b0;
    scan_tgt = '0;
    idx      = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(base) + i) % N;
      if (!scan_hit && ch_en[idx]) begin
        scan_hit = 1'b1;
        scan_tgt = SELW'(idx);
      end
    end
  end

  always_comb begin
    cap     = 1'b0;
    cap_ch  = '0;
    ptr_nxt = base;
    if (slot_free) begin
      if (!mode) begin
        if (load && sel_ok) begin
          cap    = 1'b1;
          cap_ch = sel;
        end
      end else if (scan_hit) begin
        cap     = 1'b1;
        cap_ch  = scan_tgt;
        ptr_nxt = scan_tgt;
      end
    end
  end

  assign cap_data = ch_data[cap_ch];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      mode_q    <= 1'b0;
      ptr       <= LAST;
`ifdef MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      mode_q  <= mode;
      ptr     <= ptr_nxt;
      sel_err <= !mode && load && !sel_ok;
      if (slot_free) begin
        out_valid <= cap;
        if (cap) begin
          out_data <= cap_data;
          out_ch   <= cap_ch;
`ifdef MUX_PARITY_EN
          out_par  <= ^cap_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed self-checking bench for mux_nx1_scan: an N=4 instance for the main behaviour,
// an N=3 instance for out-of-range select errors. Parity checks build with MUX_PARITY_EN.
module tb_mux_nx1_scan;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  ch_en;
  logic        mode;
  logic [1:0]  sel;
  logic        load;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        sel_err;

  logic [23:0] in_data3;
  logic [2:0]  ch_en3;
  logic        mode3;
  logic [1:0]  sel3;
  logic        load3;
  logic        ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        sel_err3;

`ifdef MUX_PARITY_EN
  logic        out_par;
  logic        out_par3;
`endif

  int checks = 0;
  int errors = 0;

  mux_nx1_scan #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .ch_en(ch_en), .mode(mode),
    .sel(sel), .load(load), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .sel_err(sel_err)
  );

  mux_nx1_scan #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .ch_en(ch_en3), .mode(mode3),
    .sel(sel3), .load(load3), .out_data(out_data3), .out_ch(out_ch3),
    .out_valid(out_valid3), .out_ready(ready3),
`ifdef MUX_PARITY_EN
    .out_par(out_par3),
`endif
    .sel_err(sel_err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    automatic logic [1:0] scan_seq [8] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
    automatic logic [7:0] scan_dat [8] = '{8'hA0, 8'hB1, 8'hD3, 8'hA0, 8'hB1, 8'hD3, 8'hA0, 8'hB1};

    rst_n     = 1'b0;
    in_data   = 32'hD3C2B1A0;
    ch_en     = 4'b0000;
    mode      = 1'b0;
    sel       = 2'd0;
    load      = 1'b0;
    out_ready = 1'b1;
    in_data3  = 24'hC2B1A0;
    ch_en3    = 3'b000;
    mode3     = 1'b0;
    sel3      = 2'd0;
    load3     = 1'b0;
    ready3    = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("rst_data", 64'(out_data), 64'h0);
    checkOutput("rst_ch", 64'(out_ch), 64'h0);
    checkOutput("rst_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_sel_err", 64'(sel_err), 64'h0);
    checkOutput("rst_valid3", 64'(out_valid3), 64'h0);
    rst_n = 1'b1;
    tick();

    // Direct capture of channel 2
    sel  = 2'd2;
    load = 1'b1;
    tick();
    checkOutput("d_data", 64'(out_data), 64'hC2);
    checkOutput("d_ch", 64'(out_ch), 64'd2);
    checkOutput("d_valid", 64'(out_valid), 64'd1);

    // Capture channel 1, then hold under back-pressure while inputs change
    sel = 2'd1;
    tick();
    checkOutput("bp_cap_data", 64'(out_data), 64'hB1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel     = 2'(i + 2);
      in_data = 32'h11223344 + 32'(i);
      tick();
      checkOutput("bp_hold_data", 64'(out_data), 64'hB1);
      checkOutput("bp_hold_ch", 64'(out_ch), 64'd1);
      checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    sel       = 2'd3;
    in_data   = 32'h5A000000;
    out_ready = 1'b1;
    tick();
    checkOutput("bp_rel_data", 64'(out_data), 64'h5A);
    checkOutput("bp_rel_ch", 64'(out_ch), 64'd3);
    load = 1'b0;
    tick();
    checkOutput("idle_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_data", 64'(out_data), 64'h5A);
    checkOutput("idle_ch", 64'(out_ch), 64'd3);
    in_data = 32'hD3C2B1A0;

    // Scan over channels 0,1,3
    mode  = 1'b1;
    ch_en = 4'b1011;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("scan_ch", 64'(out_ch), 64'(scan_seq[i]));
      checkOutput("scan_data", 64'(out_data), 64'(scan_dat[i]));
      checkOutput("scan_valid", 64'(out_valid), 64'd1);
    end
    ch_en = 4'b0000;
    tick();
    checkOutput("scan_off_valid", 64'(out_valid), 64'd0);
    checkOutput("scan_off_ch", 64'(out_ch), 64'd1);
    tick();
    checkOutput("scan_off_valid2", 64'(out_valid), 64'd0);
    ch_en = 4'b1011;
    tick();
    checkOutput("scan_ptr_held", 64'(out_ch), 64'd3);
    tick();
    tick();
    checkOutput("scan_pre_sw", 64'(out_ch), 64'd1);

    // Scan -> direct idle -> scan restarts from lowest enabled
    mode = 1'b0;
    tick();
    checkOutput("sw_idle_valid", 64'(out_valid), 64'd0);
    mode  = 1'b1;
    ch_en = 4'b1100;
    tick();
    checkOutput("sw_first", 64'(out_ch), 64'd2);
    tick();
    checkOutput("sw_second", 64'(out_ch), 64'd3);
    tick();
    checkOutput("sw_third", 64'(out_ch), 64'd2);

    // Switch cycle capture uses direct rules; ptr=2 is discarded on return to scan
    mode = 1'b0;
    load = 1'b1;
    sel  = 2'd0;
    tick();
    checkOutput("sw_direct_ch", 64'(out_ch), 64'd0);
    checkOutput("sw_direct_data", 64'(out_data), 64'hA0);
    load = 1'b0;
    mode = 1'b1;
    tick();
    checkOutput("sw_restart_ch", 64'(out_ch), 64'd2);
    tick();
    checkOutput("pre_rst_ch", 64'(out_ch), 64'd3);

    // Asynchronous reset mid-scan
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_data", 64'(out_data), 64'h0);
    checkOutput("arst_ch", 64'(out_ch), 64'd0);
    tick();
    rst_n = 1'b1;
    mode  = 1'b0;
    ch_en = 4'b0000;
    tick();

`ifdef MUX_PARITY_EN
    load = 1'b1;
    sel  = 2'd0;
    tick();
    checkOutput("par_A0", 64'(out_par), 64'd0);
    sel = 2'd1;
    tick();
    checkOutput("par_B1", 64'(out_par), 64'd0);
    in_data = 32'hD3C2B101;
    sel     = 2'd0;
    tick();
    checkOutput("par_01", 64'(out_par), 64'd1);
    load = 1'b0;
`endif

    // Out-of-range select on the N=3 instance
    sel3  = 2'd3;
    load3 = 1'b1;
    tick();
    checkOutput("n3_err_pulse", 64'(sel_err3), 64'd1);
    checkOutput("n3_err_valid", 64'(out_valid3), 64'd0);
    load3 = 1'b0;
    tick();
    checkOutput("n3_err_clear", 64'(sel_err3), 64'd0);
    sel3  = 2'd1;
    load3 = 1'b1;
    tick();
    checkOutput("n3_cap_data", 64'(out_data3), 64'hB1);
    checkOutput("n3_cap_err", 64'(sel_err3), 64'd0);
    ready3 = 1'b0;
    sel3   = 2'd3;
    tick();
    checkOutput("n3_busy_err", 64'(sel_err3), 64'd1);
    checkOutput("n3_busy_valid", 64'(out_valid3), 64'd1);
    checkOutput("n3_busy_data", 64'(out_data3), 64'hB1);
    load3 = 1'b0;
    tick();
    checkOutput("n3_busy_clear", 64'(sel_err3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
